// File: rtl/tmds_pkg.sv
`default_nettype none
// tmds_pkg: TMDS control-token table, alignment state encoding and token matcher.
// Shared by the channel decoder and the channel encoder.
package tmds_pkg;

    localparam logic [9:0] CTKN_00 = 10'b1101010100;
    localparam logic [9:0] CTKN_01 = 10'b0010101011;
    localparam logic [9:0] CTKN_10 = 10'b0101010100;
    localparam logic [9:0] CTKN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_t;

    // Returns {hit, c1, c0}; c bits are zero when the word is not a token.
    function automatic logic [2:0] is_ctkn(input logic [9:0] word);
        logic [2:0] r;
        case (word)
            CTKN_00: r = 3'b100;
            CTKN_01: r = 3'b101;
            CTKN_10: r = 3'b110;
            CTKN_11: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_word_dec.sv
`default_nettype none
// tmds_word_dec: combinational decode of one aligned 10-bit TMDS word.
// Tokens give c1/c0 with vde=0; every other word is treated as video.
module tmds_word_dec
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic       vde,
    output logic       c1,
    output logic       c0,
    output logic [7:0] dout
);

    logic [2:0] tok;
    logic [7:0] d;

    always_comb begin
        tok  = is_ctkn(word);
        d    = word[9] ? ~word[7:0] : word[7:0];
        vde  = ~tok[2];
        c1   = tok[1];
        c0   = tok[0];
        dout = 8'd0;
        if (!tok[2]) begin
            dout[0] = d[0];
            // word[8] records whether the encoder chained with XOR or XNOR
            for (int i = 1; i < 8; i++) begin
                dout[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmds_chan_decoder.sv
`default_nettype none
// tmds_chan_decoder: one TMDS receive channel. Finds word alignment from control-token
// runs (driving bitslip), then decodes pixels and sync bits with a 2-cycle pipeline.
module tmds_chan_decoder
    import tmds_pkg::*;
#(
    parameter int CTKN_RUN   = 128,
    parameter int SEARCH_TO  = 4096,
    parameter int SETTLE_CYC = 16,
    parameter int LOSS_TO    = 4096
) (
    input  logic       pclk,
    input  logic       rstin_,
    input  logic [9:0] sdata,
    output logic       bitslip,
    output logic       aligned,
    output logic [3:0] slip_cnt,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       vde
);

    localparam int RUN_W = (CTKN_RUN   > 1) ? $clog2(CTKN_RUN)   : 1;
    localparam int SRCH_W = (SEARCH_TO > 1) ? $clog2(SEARCH_TO)  : 1;
    localparam int STL_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int GAP_W = (LOSS_TO    > 1) ? $clog2(LOSS_TO)    : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTKN_RUN - 1);
    localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_TO - 1);
    localparam logic [STL_W-1:0]  STL_LAST  = STL_W'(SETTLE_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LOSS_TO - 1);

    align_state_t      state, state_nx;
    logic [2:0]        tok_now;
    logic [RUN_W-1:0]  run_cnt;
    logic [SRCH_W-1:0] srch_cnt;
    logic [STL_W-1:0]  settle_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    assign tok_now = is_ctkn(sdata);

    always_ff @(posedge pclk or negedge rstin_) begin
        if (!rstin_) state <= ST_SEARCH;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_SEARCH: begin
                // A completed token run wins over a coincident search timeout
                if (tok_now[2] && run_cnt == RUN_LAST) state_nx = ST_LOCKED;
                else if (srch_cnt == SRCH_LAST)         state_nx = ST_SLIP;
            end
            ST_SLIP:   state_nx = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == STL_LAST) state_nx = ST_SEARCH;
            ST_LOCKED: if (!tok_now[2] && gap_cnt == GAP_LAST) state_nx = ST_SEARCH;
            default:   state_nx = ST_SEARCH;
        endcase
    end

    always_ff @(posedge pclk or negedge rstin_) begin
        if (!rstin_) begin
            run_cnt    <= '0;
            srch_cnt   <= '0;
            settle_cnt <= '0;
            gap_cnt    <= '0;
            slip_cnt   <= 4'd0;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
        end else begin
            if (state == ST_SEARCH && state_nx == ST_SEARCH) begin
                run_cnt  <= !tok_now[2] ? '0 : (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
                srch_cnt <= (srch_cnt == '1) ? srch_cnt : srch_cnt + 1'b1;
            end else begin
                run_cnt  <= '0;
                srch_cnt <= '0;
            end
            if (state == ST_SETTLE && state_nx == ST_SETTLE && settle_cnt != '1)
                settle_cnt <= settle_cnt + 1'b1;
            else if (state != ST_SETTLE || state_nx != ST_SETTLE)
                settle_cnt <= '0;
            if (state == ST_LOCKED && state_nx == ST_LOCKED && !tok_now[2])
                gap_cnt <= (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;
            else
                gap_cnt <= '0;
            if (state_nx == ST_SLIP)
                slip_cnt <= (slip_cnt >= 4'd9) ? 4'd0 : slip_cnt + 4'd1;
            bitslip <= (state_nx == ST_SLIP);
            aligned <= (state_nx == ST_LOCKED);
        end
    end

    // Decode pipeline: stage 1 captures the raw word, stage 2 decodes and gates.
    logic [9:0] s1_word;
    logic [2:0] s1_tok;
    logic [1:0] c_last;
    logic       dec_vde, dec_c1, dec_c0;
    logic [7:0] dec_dout;

    always_ff @(posedge pclk or negedge rstin_) begin
        if (!rstin_) begin
            s1_word <= 10'd0;
            s1_tok  <= 3'd0;
        end else begin
            s1_word <= sdata;
            s1_tok  <= tok_now;
        end
    end

    tmds_word_dec u_word_dec (
        .word (s1_word),
        .vde  (dec_vde),
        .c1   (dec_c1),
        .c0   (dec_c0),
        .dout (dec_dout)
    );

    always_ff @(posedge pclk or negedge rstin_) begin
        if (!rstin_) begin
            c_last <= 2'b00;
            dout   <= 8'd0;
            vde    <= 1'b0;
            c1     <= 1'b0;
            c0     <= 1'b0;
        end else begin
            if (s1_tok[2]) c_last <= s1_tok[1:0];
            if (!aligned) begin
                dout <= 8'd0;
                vde  <= 1'b0;
                c1   <= 1'b0;
                c0   <= 1'b0;
            end else if (dec_vde) begin
                dout     <= dec_dout;
                vde      <= 1'b1;
                {c1, c0} <= c_last;
            end else begin
                dout <= 8'd0;
                vde  <= 1'b0;
                c1   <= dec_c1;
                c0   <= dec_c0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmds_chan_decoder.sv
`default_nettype none
// tb_tmds_chan_decoder: directed-vector bench for the TMDS channel decoder,
// including a bit-rotating deserializer model that honours bitslip.
module tb_tmds_chan_decoder;

    localparam int LINE     = 2200;
    localparam int ACTIVE   = 1920;
    localparam int HBLANK   = 280;
    localparam int HS_START = 88;
    localparam int HS_LEN   = 44;
    localparam int MIN_SLIP_GAP = 4096 + 16 + 1;

    localparam logic [9:0] TK00 = 10'b1101010100;
    localparam logic [9:0] TOKS [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};

    logic       pclk = 1'b0;
    logic       rstin_ = 1'b0;
    logic [9:0] sdata = 10'd0;
    logic       bitslip, aligned, c0, c1, vde;
    logic [3:0] slip_cnt;
    logic [7:0] dout;

    tmds_chan_decoder dut (
        .pclk     (pclk),
        .rstin_   (rstin_),
        .sdata    (sdata),
        .bitslip  (bitslip),
        .aligned  (aligned),
        .slip_cnt (slip_cnt),
        .dout     (dout),
        .c0       (c0),
        .c1       (c1),
        .vde      (vde)
    );

    always #5 pclk = ~pclk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference TMDS data encoder (transition-minimising stage; q[9] kept at 0).
    function automatic logic [9:0] enc(input logic [7:0] d);
        logic [8:0] qm;
        int ones;
        ones  = $countones(d);
        qm[0] = d[0];
        if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        return {1'b0, qm};
    endfunction

    typedef struct packed {
        logic [9:0] w;
        logic       vde;
        logic [1:0] c;
        logic [7:0] d;
    } wv_t;

    // Word at stream position p: 280 blanking tokens then 1920 pixels per line.
    function automatic wv_t gen(input int p);
        wv_t r;
        int  lp, ln;
        logic vs, hs;
        lp = p % LINE;
        ln = p / LINE;
        vs = ln[1];
        r  = '0;
        if (lp < HBLANK) begin
            hs    = (lp >= HS_START && lp < HS_START + HS_LEN);
            r.w   = TOKS[{vs, hs}];
            r.c   = {vs, hs};
        end else begin
            r.d   = 8'((lp * 7 + ln) % 256);
            r.w   = enc(r.d);
            r.vde = 1'b1;
        end
        return r;
    endfunction

    int   cyc = 0;
    int   n_slip = 0;
    int   last_slip_cyc = -1;
    int   min_gap = 1000000000;
    int   dbl = 0;
    logic prev_bs = 1'b0;

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
        if (bitslip) begin
            n_slip++;
            if (last_slip_cyc >= 0 && (cyc - last_slip_cyc) < min_gap)
                min_gap = cyc - last_slip_cyc;
            if (prev_bs) dbl++;
            last_slip_cyc = cyc;
        end
        prev_bs = bitslip;
    endtask

    task automatic drive(input logic [9:0] w);
        sdata = w;
        tick();
    endtask

    task automatic drive_n(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) drive(w);
    endtask

    int   pos = 0;
    int   off = 0;
    logic [1:0] last_c = 2'b00;
    wv_t  prev_e = '0;
    logic meas = 1'b0;
    int   vde_cnt, mis_v, mis_c, mis_d;

    // Serial stream seen through a window offset by 'off' bits; each bitslip moves it one bit.
    task automatic stream_cycle();
        wv_t a, b, e;
        logic [19:0] pair;
        a    = gen(pos);
        b    = gen(pos + 1);
        pair = {b.w, a.w};
        sdata = pair[off +: 10];
        e = a;
        if (a.vde) e.c = last_c;
        else       last_c = a.c;
        pos++;
        tick();
        if (meas) begin
            if (vde) vde_cnt++;
            if (vde !== prev_e.vde)      mis_v++;
            if ({c1, c0} !== prev_e.c)   mis_c++;
            if (dout !== prev_e.d)       mis_d++;
        end
        prev_e = e;
        if (bitslip) begin
            off++;
            if (off == 10) begin
                off = 0;
                pos++;
            end
        end
    endtask

    logic [9:0]  vw [9];
    logic [10:0] ve [9];
    int t0;
    int slips_before;

    initial begin
        vw[0] = 10'b0101100011; ve[0] = 11'h4A5;   // 0xA5, XOR-chained
        vw[1] = TOKS[1];        ve[1] = 11'h100;
        vw[2] = 10'b1110011100; ve[2] = 11'h5A5;   // 0xA5, inverted form, c held at 01
        vw[3] = TOKS[3];        ve[3] = 11'h300;
        vw[4] = 10'b0011111111; ve[4] = 11'h7FF;
        vw[5] = TOKS[2];        ve[5] = 11'h200;
        vw[6] = 10'b0100000000; ve[6] = 11'h600;
        vw[7] = 10'b0100000001; ve[7] = 11'h603;
        vw[8] = TK00;           ve[8] = 11'h000;

        repeat (3) tick();
        check("rst_bitslip",  32'(bitslip),  32'd0);
        check("rst_aligned",  32'(aligned),  32'd0);
        check("rst_slip_cnt", 32'(slip_cnt), 32'd0);
        check("rst_dout",     32'(dout),     32'd0);
        check("rst_c0",       32'(c0),       32'd0);
        check("rst_c1",       32'(c1),       32'd0);
        check("rst_vde",      32'(vde),      32'd0);
        rstin_ = 1'b1;

        // Aligned source: lock on the 128th token, then decode a vector table
        drive_n(TK00, 127);
        check("t2_aligned_after_127", 32'(aligned), 32'd0);
        drive(TK00);
        check("t2_aligned_after_128", 32'(aligned), 32'd1);
        drive_n(TK00, 72);
        for (int i = 0; i < 9; i++) begin
            drive(vw[i]);
            if (i > 0) check($sformatf("t2_vec%0d", i - 1), 32'({vde, c1, c0, dout}), 32'(ve[i-1]));
        end
        drive(TK00);
        check("t2_vec8", 32'({vde, c1, c0, dout}), 32'(ve[8]));

        // Bit-offset stream starting 3 bits off
        rstin_ = 1'b0;
        tick();
        tick();
        rstin_ = 1'b1;
        pos = 0; off = 3; last_c = 2'b00; prev_e = '0;
        n_slip = 0; last_slip_cyc = -1; min_gap = 1000000000; dbl = 0;
        t0 = cyc;
        while (!aligned && (cyc - t0) < 40000) stream_cycle();
        check("t3_aligned",      32'(aligned),  32'd1);
        check("t3_slip_pulses",  32'(n_slip),   32'd7);
        check("t3_slip_cnt",     32'(slip_cnt), 32'd7);
        check("t3_gap_ok",       32'(min_gap >= MIN_SLIP_GAP), 32'd1);
        check("t3_no_dbl_pulse", 32'(dbl),      32'd0);

        // Sync and pixel decode over three full lines once aligned
        while ((pos % LINE) != 1) stream_cycle();
        for (int ln = 0; ln < 3; ln++) begin
            vde_cnt = 0; mis_v = 0; mis_c = 0; mis_d = 0;
            meas = 1'b1;
            repeat (LINE) stream_cycle();
            meas = 1'b0;
            check($sformatf("t4_line%0d_vde_cnt", ln), 32'(vde_cnt), 32'(ACTIVE));
            check($sformatf("t4_line%0d_vde_err", ln), 32'(mis_v),   32'd0);
            check($sformatf("t4_line%0d_sync_err", ln), 32'(mis_c),  32'd0);
            check($sformatf("t4_line%0d_dout_err", ln), 32'(mis_d),  32'd0);
        end
        check("t4_no_extra_slip", 32'(n_slip), 32'd7);

        // Lock loss after 4096 non-token words, then relock
        slips_before = n_slip;
        drive_n(enc(8'h55), 4095);
        check("t6_aligned_at_4095", 32'(aligned), 32'd1);
        drive(enc(8'h55));
        check("t6_aligned_lost", 32'(aligned), 32'd0);
        drive(enc(8'h55));
        drive(enc(8'h55));
        check("t6_vde_gated",  32'(vde),  32'd0);
        check("t6_dout_gated", 32'(dout), 32'd0);
        check("t6_no_slip",    32'(n_slip), 32'(slips_before));
        check("t6_slip_kept",  32'(slip_cnt), 32'd7);
        drive_n(TK00, 127);
        check("t6_relock_127", 32'(aligned), 32'd0);
        drive(TK00);
        check("t6_relock_128", 32'(aligned), 32'd1);
        drive(enc(8'h3C));
        drive(TK00);
        check("t6_relock_pix", 32'({vde, dout}), 32'({1'b1, 8'h3C}));

        // Reset pulse mid-lock clears outputs without waiting for a clock
        #2;
        rstin_ = 1'b0;
        #2;
        check("t1_async_outs", 32'({bitslip, aligned, c1, c0, vde, dout}), 32'd0);
        check("t1_slip_cnt",   32'(slip_cnt), 32'd0);
        @(posedge pclk);
        #1;
        rstin_ = 1'b1;

        // Interrupted run: 127 + data + 127 must not lock; the next token does
        drive_n(TK00, 127);
        check("t1_search_127", 32'(aligned), 32'd0);
        drive(enc(8'h10));
        drive_n(TK00, 127);
        check("t5_no_lock", 32'(aligned), 32'd0);
        drive(TK00);
        check("t5_lock_128", 32'(aligned), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
